// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle MDU front-end freeze and syscall halt/resume, plus a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_halt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch,
  input  logic             ex_mdu_start,
  input  logic             resume,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] MDU_INIT = CW'(MDU_LAT - 2);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MDU  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;

  assign w_load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (pc_stall)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // cnt holds the MDU_BUSY cycles still to come, so the start cycle plus the busy
  // cycles freeze the front end for MDU_LAT-1 cycles in total.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (ex_mdu_start) begin
          if (MDU_LAT > 2) begin
            w_state_nxt = S_MDU;
            w_cnt_nxt   = MDU_INIT;
          end
        end else if (id_halt && !ex_branch) begin
          w_state_nxt = S_HALT;
        end
      end
      S_MDU: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_HALT: begin
        if (resume)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (ex_branch) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mdu_start) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            exmem_flush = 1'b1;
          end else if (id_halt || w_load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        S_MDU: begin
          // ID/EX keeps the MDU op in place while EX/MEM receives bubbles
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          exmem_flush = 1'b1;
        end
        S_HALT: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted    = (r_state == S_HALT);
  assign stall_cnt = r_stall_cnt;

endmodule
